// File: rtl/decoder_pkg.sv
// Shared widths, types and reference decode for the registered 3-to-8 decoder.
// Used by both the RTL and the verification environment.
package decoder_pkg;

    localparam int unsigned IN_W  = 3;
    localparam int unsigned OUT_W = 2 ** IN_W;

    typedef logic [IN_W-1:0]  code_t;
    typedef logic [OUT_W-1:0] onehot_t;

    // Unknown codes never match any index, so they fall through to all-zero.
    function automatic onehot_t onehot_f(input code_t code);
        onehot_t result;
        result = '0;
        for (int unsigned k = 0; k < OUT_W; k++) begin
            if (code == code_t'(k)) begin
                result[k] = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/decoder_3to8_onehot_dec.sv
// Purely combinational binary-to-one-hot decode with an all-zero default
// for codes that do not resolve to a valid index.
module onehot_dec #(
    parameter int unsigned IN_W = decoder_pkg::IN_W
) (
    input  logic [IN_W-1:0]      code,
    output logic [2**IN_W-1:0]   onehot
);

    localparam int unsigned OUT_W = 2 ** IN_W;

    // Equality against X/Z yields unknown, so the bit stays at its zero default.
    always_comb begin
        onehot = '0;
        for (int unsigned k = 0; k < OUT_W; k++) begin
            if (code == IN_W'(k)) begin
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_3to8.sv
// Registered binary-to-one-hot decoder: a code accepted while valid is high
// appears one-hot on out one cycle later, with a single-cycle out_valid strobe.
module decoder_3to8 #(
    parameter  int unsigned IN_W  = decoder_pkg::IN_W,
    localparam int unsigned OUT_W = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             out_valid
);

    logic [OUT_W-1:0] dec_onehot;

    onehot_dec #(
        .IN_W (IN_W)
    ) u_onehot_dec (
        .code   (in),
        .onehot (dec_onehot)
    );

    // out only moves on an accept; idle cycles hold the last decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= '0;
        end else if (valid) begin
            out <= dec_onehot;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= valid;
        end
    end

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed and randomized self-checking bench for decoder_3to8.
module tb_decoder_3to8;
    import decoder_pkg::*;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [2:0] in_code;
    logic [7:0] out;
    logic       out_valid;

    int unsigned n_tests;
    int unsigned n_fail;

    decoder_3to8 #(
        .IN_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .in        (in_code),
        .out       (out),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive at edge+1, let the next rising edge sample, observe at edge+1.
    task automatic step(input logic v, input logic [2:0] c);
        valid   = v;
        in_code = c;
        @(posedge clk);
        #1;
    endtask

    // 3 ns low pulse on rst placed between edges; checks the async clear.
    task automatic reset_pulse(input string tag);
        #2;
        rst = 1'b0;
        #1;
        check({tag, "_out_async"}, {24'd0, out}, 32'h00);
        check({tag, "_ov_async"}, {31'd0, out_valid}, 32'h0);
        #2;
        rst = 1'b1;
    endtask

    logic [7:0] sweep_exp [8];
    logic [7:0] exp_out;
    logic       exp_ov;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        rst     = 1'b0;
        valid   = 1'b0;
        in_code = 3'd0;
        #3;
        check("reset_out", {24'd0, out}, 32'h00);
        check("reset_ov", {31'd0, out_valid}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 3'd6);
        check("release_out", {24'd0, out}, 32'h00);
        check("release_ov", {31'd0, out_valid}, 32'h0);

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i));
            check($sformatf("sweep_out_%0d", i), {24'd0, out}, {24'd0, sweep_exp[i]});
            check($sformatf("sweep_ov_%0d", i), {31'd0, out_valid}, 32'h1);
        end

        step(1'b1, 3'd3);
        check("hold_accept", {24'd0, out}, 32'h08);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 3'(i * 3 + 1));
            check($sformatf("hold_out_%0d", i), {24'd0, out}, 32'h08);
            check($sformatf("hold_ov_%0d", i), {31'd0, out_valid}, 32'h0);
        end

        step(1'b1, 3'd7);
        check("b2b_first", {24'd0, out}, 32'h80);
        step(1'b1, 3'd0);
        check("b2b_second", {24'd0, out}, 32'h01);
        check("b2b_ov", {31'd0, out_valid}, 32'h1);

        step(1'b1, 3'd4);
        check("pre_reset_out", {24'd0, out}, 32'h10);
        valid = 1'b0;
        reset_pulse("rst_idle");
        @(posedge clk);
        #1;
        check("rst_idle_hold_out", {24'd0, out}, 32'h00);
        check("rst_idle_hold_ov", {31'd0, out_valid}, 32'h0);

        step(1'b1, 3'd5);
        step(1'b1, 3'd5);
        check("stream_out", {24'd0, out}, 32'h20);
        reset_pulse("rst_stream");
        valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_stream_after", {24'd0, out}, 32'h00);
        step(1'b1, 3'd2);
        check("rst_stream_cold", {24'd0, out}, 32'h04);
        check("rst_stream_cold_ov", {31'd0, out_valid}, 32'h1);

        exp_out = out;
        for (int i = 0; i < 1000; i++) begin
            logic       v;
            logic [2:0] c;
            v = 1'($urandom_range(0, 1));
            c = 3'($urandom_range(0, 7));
            step(v, c);
            if (v) begin
                exp_out = onehot_f(c);
            end
            exp_ov = v;
            check("rand_out", {24'd0, out}, {24'd0, exp_out});
            check("rand_ov", {31'd0, out_valid}, {31'd0, exp_ov});
            check("rand_onehot", {31'd0, (out == 8'h00) || $onehot(out)}, 32'h1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_3to8.md
Name: decoder_3to8

Overview:
- Registered 3-to-8 binary-to-one-hot decoder.
- A 3-bit code is sampled on a rising clk edge while `valid` is high.
- The matching one-hot byte is driven on `out` one cycle later.
- Used as a leaf select/enable generator. Intended as a standalone unit for block-level verification through the team's standard interface/test environment.

Parameters:
- IN_W, 3, width of the binary input code; must be ≥1.
- OUT_W, 2**IN_W (derived localparam, not overridable), width of the one-hot output; 8 at default.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous active-low reset (rst=0 resets, rst=1 runs)
- valid  input  1  input qualifier; `in` is sampled only when high
- in  input  IN_W  binary code to decode
- out  output  OUT_W  registered one-hot result; out[k]=1 iff last accepted code==k
- out_valid  output  1  high for exactly one cycle after each accepted code

Behaviour:
- Reset:
  - rst falling asserts reset immediately, without waiting for clk.
  - While rst=0: out=0 (all bits low) and out_valid=0.
  - Release is synchronised by the first rising clk with rst=1; no output change occurs at the release itself.
- Accept: on rising clk with rst=1 and valid=1:
  - out <= (1 << in), exactly one bit set.
  - out_valid <= 1.
- Idle: on rising clk with rst=1 and valid=0:
  - out holds its previous value.
  - out_valid <= 0.
- Latency: fixed at 1 cycle from the accepting edge. Throughput is one code per cycle; back-to-back valid cycles each update out.
- No combinational path from in/valid to out or out_valid; both are flops.
- X/Z on `in` while valid=1: out <= 0, out_valid <= 1 (defensive decode default); never propagate X.
- Output invariants:
  - After the first accept, out is always one-hot (popcount==1) until the next reset.
  - Before the first accept, out is 0.
- Reset mid-operation: outputs clear asynchronously; the pending decode is discarded. The first post-reset accept behaves like a cold start.
- Repeated identical codes: out is unchanged and out_valid stays high for each accepting cycle.

Decomposition:
- Shared package decoder_pkg holds:
  - IN_W default (3) and derived OUT_W
  - typedef code_t (logic [IN_W-1:0])
  - typedef onehot_t (logic [OUT_W-1:0])
  - function onehot_f(code_t) returning onehot_t, for reuse by the DUT and the scoreboard/reference model
- One natural sub-module: onehot_dec, a purely combinational decode of code_t to onehot_t including the X-default.
- The top level holds only the valid-gated output register and the out_valid flop.

Test Plan:
- Reset: assert rst=0 mid-cycle with out=8'h10 → out=8'h00 and out_valid=0 immediately, before the next clk edge; outputs stay 0 until valid is seen after release.
- Exhaustive sweep: valid=1, in=0..7 on consecutive cycles → out=01,02,04,08,10,20,40,80 one cycle after each input; out_valid=1 throughout.
- Hold: accept in=3 (out=8'h08), then valid=0 for 5 cycles with in toggling → out stays 8'h08 and out_valid=0 after the first idle edge.
- Back-to-back: in=7 then in=0 on adjacent valid cycles → out=8'h80, then 8'h01 on the following edge, with no intermediate value.
- Mid-stream reset: streaming in=5 with valid=1, pulse rst=0 for 3 ns between edges → out drops to 0 at once; the next accepted in=2 yields 8'h04.
- Randomized: 1000 cycles of random valid/in against decoder_pkg::onehot_f → zero mismatches; out is one-hot whenever nonzero.
